// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_pkg                                                      |
// | Description : Shared funct3 encodings, FSM state type and alignment check  |
// |               for the load/store unit.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic w_mis;
        case (funct3)
            F3_H, F3_HU: w_mis = addr_lo[0];
            F3_W:        w_mis = (addr_lo != 2'b00);
            default:     w_mis = 1'b0;
        endcase
        return w_mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_lane                                                     |
// | Description : Combinational lane logic: load extract/extend and            |
// |               sub-word store merge into the old memory word.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [15:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = old_word[7:0];
            2'd1:    w_byte = old_word[15:8];
            2'd2:    w_byte = old_word[23:16];
            default: w_byte = old_word[31:24];
        endcase
        w_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   load_data = {24'h0, w_byte};
            F3_HU:   load_data = {16'h0, w_half};
            default: load_data = old_word;
        endcase
    end

    // funct3[0] separates SH (1) from SB (0); only those two reach the merge.
    always_comb begin
        merged_word = old_word;
        if (funct3[0]) begin
            if (addr_lo[1]) merged_word[31:16] = new_data;
            else            merged_word[15:0]  = new_data;
        end else begin
            case (addr_lo)
                2'd0:    merged_word[7:0]   = new_data[7:0];
                2'd1:    merged_word[15:8]  = new_data[7:0];
                2'd2:    merged_word[23:16] = new_data[7:0];
                default: merged_word[31:24] = new_data[7:0];
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit                                              |
// | Description : MEM-stage initiator: loads, word stores, and SB/SH as a      |
// |               two-cycle read-modify-write with fault rejection.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    output logic        rsp_valid,
    output logic        stall,
    output logic        fault,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;
    logic [31:0] r_merged;
    logic [31:0] r_idx;

    logic [31:0] w_word_idx;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;
    logic        w_illegal;
    logic        w_oor;
    logic        w_fault;
    logic        w_capture;

    assign w_word_idx = {2'b00, req_addr[31:2]};
    assign w_oor      = (w_word_idx >= 32'(MEM_WORDS));

    always_comb begin
        if (req_we) begin
            w_illegal = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
        end else begin
            w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
    end

    assign w_fault = w_illegal || w_oor || is_misaligned(req_funct3, req_addr[1:0]);

    lsu_lane u_lane (
        .funct3      (req_funct3),
        .addr_lo     (req_addr[1:0]),
        .old_word    (mem_rd),
        .new_data    (req_wdata[15:0]),
        .load_data   (w_load_data),
        .merged_word (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_merged <= 32'h0;
            r_idx    <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_merged <= w_merged;
                r_idx    <= w_word_idx;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        rsp_rdata    = 32'h0;
        rsp_valid    = 1'b0;
        stall        = 1'b0;
        fault        = 1'b0;
        mem_a        = 32'h0;
        mem_wd       = 32'h0;
        mem_we       = 1'b0;
        if (rst) begin
            // Outputs stay at their inactive defaults; an in-flight RMW is dropped.
            w_next_state = IDLE;
        end else begin
            case (r_state)
                RMW_WR: begin
                    mem_a        = r_idx;
                    mem_wd       = r_merged;
                    mem_we       = 1'b1;
                    rsp_valid    = 1'b1;
                    w_next_state = IDLE;
                end
                default: begin
                    if (req_valid) begin
                        mem_a = w_word_idx;
                        if (w_fault) begin
                            fault = 1'b1;
                        end else if (!req_we) begin
                            rsp_rdata = w_load_data;
                            rsp_valid = 1'b1;
                        end else if (req_funct3 == F3_W) begin
                            mem_wd    = req_wdata;
                            mem_we    = 1'b1;
                            rsp_valid = 1'b1;
                        end else begin
                            stall        = 1'b1;
                            w_capture    = 1'b1;
                            w_next_state = RMW_WR;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                           |
// | Description : Scoreboard bench for load_store_unit with a behavioural      |
// |               word memory.                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_valid;
    logic        stall;
    logic        fault;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic        mem_init;
    logic [31:0] mem [0:1023];

    typedef struct packed {
        logic [31:0] data;
        logic        chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_rdata  (rsp_rdata),
        .rsp_valid  (rsp_valid),
        .stall      (stall),
        .fault      (fault),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = (mem_a < 32'd1024) ? mem[mem_a[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[5] <= 32'h8899AABB;
        end else if (mem_we && mem_a < 32'd1024) begin
            mem[mem_a[9:0]] <= mem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each completion pops the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.chk) check("rsp_rdata", rsp_rdata, e.data);
            end
        end
    end

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        sb_q.push_back('{data: exp, chk: 1'b1});
        @(negedge clk);
        check("ld_valid", {31'h0, rsp_valid}, 32'd1);
        check("ld_stall", {31'h0, stall}, 32'd0);
        check("ld_fault", {31'h0, fault}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic sw_op(input logic [31:0] a, input logic [31:0] wd);
        drive(1'b1, 1'b1, 3'b010, a, wd);
        sb_q.push_back('{data: 32'h0, chk: 1'b0});
        @(negedge clk);
        check("sw_we", {31'h0, mem_we}, 32'd1);
        check("sw_a", mem_a, a >> 2);
        check("sw_wd", mem_wd, wd);
        check("sw_stall", {31'h0, stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic sub_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_word);
        drive(1'b1, 1'b1, f3, a, wd);
        sb_q.push_back('{data: 32'h0, chk: 1'b0});
        @(negedge clk);
        check("rmw1_stall", {31'h0, stall}, 32'd1);
        check("rmw1_we", {31'h0, mem_we}, 32'd0);
        check("rmw1_valid", {31'h0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rmw2_stall", {31'h0, stall}, 32'd0);
        check("rmw2_we", {31'h0, mem_we}, 32'd1);
        check("rmw2_a", mem_a, a >> 2);
        check("rmw2_wd", mem_wd, exp_word);
        @(posedge clk); #1;
    endtask

    task automatic fault_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
        drive(1'b1, we, f3, a, wd);
        @(negedge clk);
        check("flt_fault", {31'h0, fault}, 32'd1);
        check("flt_we", {31'h0, mem_we}, 32'd0);
        check("flt_stall", {31'h0, stall}, 32'd0);
        check("flt_valid", {31'h0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        mem_init = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
        @(negedge clk);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_we", {31'h0, mem_we}, 32'd0);
        check("rst_a", mem_a, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        load_op(3'b000, 32'h15, 32'hFFFFFFAA);
        load_op(3'b100, 32'h15, 32'h000000AA);
        load_op(3'b001, 32'h16, 32'hFFFF8899);

        sub_op(3'b000, 32'h16, 32'h12345677, 32'h8877AABB);
        load_op(3'b010, 32'h14, 32'h8877AABB);

        fault_op(1'b1, 3'b001, 32'h13, 32'h0000FFFF);
        fault_op(1'b0, 3'b010, 32'h16, 32'h0);
        fault_op(1'b0, 3'b011, 32'h14, 32'h0);
        fault_op(1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF);
        fault_op(1'b1, 3'b100, 32'h14, 32'hFFFFFFFF);
        check("mem4_unchanged", mem[4], 32'h0);
        check("mem5_unchanged", mem[5], 32'h8877AABB);

        sw_op(32'h20, 32'hDEADBEEF);
        load_op(3'b101, 32'h22, 32'h0000DEAD);

        drive(1'b1, 1'b1, 3'b001, 32'h14, 32'h0000CAFE);
        @(negedge clk);
        check("rstrmw_stall", {31'h0, stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstrmw_we", {31'h0, mem_we}, 32'd0);
        check("rstrmw_valid", {31'h0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstrmw_mem", mem[5], 32'h8877AABB);
        load_op(3'b010, 32'h14, 32'h8877AABB);

        sub_op(3'b000, 32'h14, 32'h00000011, 32'h8877AA11);
        sub_op(3'b000, 32'h15, 32'h00000022, 32'h88772211);
        load_op(3'b010, 32'h14, 32'h88772211);

        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check("idle_we", {31'h0, mem_we}, 32'd0);
        @(posedge clk); #1;
        check("sb_drain", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator for the pipeline's word-wide data memory (asynchronous read, synchronous write at posedge, word-indexed, no byte enables). It turns load and store requests into memory accesses:
- RV32I byte, halfword and word loads, signed and unsigned, with lane extraction and extension.
- SB/SH as a two-cycle read-modify-write, stalling the pipeline for one cycle.
- Fault flag, with no memory side effect, for misaligned, out-of-range and illegal-funct3 requests.

## Interface
- `MEM_WORDS`, default 1024: data memory depth in 32-bit words; word indices at or above this value are out of range.
- `clk` in 1: the single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: MEM-stage memory op present this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data (rs2).
- `rsp_rdata` out 32: extended load result.
- `rsp_valid` out 1: op completes this cycle.
- `stall` out 1: upstream holds `req_*` and pipeline registers.
- `fault` out 1: request rejected this cycle.
- `mem_a` out 32: word index, `req_addr[31:2]`, zero-extended.
- `mem_wd` out 32: memory write data.
- `mem_we` out 1: memory write enable.
- `mem_rd` in 32: memory read data (combinational from `mem_a`).

## Operation
- **States:** IDLE, RMW_WR.
- **Fault check (IDLE, `req_valid`=1):** the request faults on any of:
  - LH/LHU/SH with `addr[0]`=1;
  - LW/SW with `addr[1:0]`≠0;
  - word index ≥ `MEM_WORDS`;
  - illegal funct3 (loads 011/110/111; stores any value other than 000/001/010).
- **Fault response:** `fault`=1, `mem_we`=0, `rsp_valid`=0, `stall`=0. State stays IDLE.
- **Load (IDLE):** `mem_a` driven from `req_addr`.
  - Byte lane `addr[1:0]`, halfword lane `addr[1]`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - `rsp_rdata` and `rsp_valid`=1 are valid the same cycle.
- **SW (IDLE):** `mem_we`=1, `mem_wd`=`req_wdata`, `rsp_valid`=1, same cycle. No stall.
- **SB/SH, cycle 1 (IDLE → RMW_WR):**
  - `mem_a` = word index, read `mem_rd`.
  - Register the merged word (`req_wdata[7:0]` or `[15:0]` inserted into the selected lane, other lanes from `mem_rd`) and the word index.
  - `stall`=1, `mem_we`=0, `rsp_valid`=0.
- **SB/SH, cycle 2 (RMW_WR → IDLE):**
  - `mem_a` = registered index, `mem_wd` = registered merged word, `mem_we`=1.
  - `rsp_valid`=1, `stall`=0.
  - `req_*` is ignored in RMW_WR; it is the same held request.
- **`req_valid`=0 in IDLE:** all outputs inactive, `mem_we`=0.
- **`rst`=1:**
  - Next state IDLE; merge registers cleared.
  - Outputs forced combinationally: `rsp_rdata`=0, `rsp_valid`=0, `stall`=0, `fault`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0.
  - A store in RMW_WR when `rst` is asserted is dropped (never written).

## Timing
- **Latency:** loads, SW and faults take 0 extra cycles (complete in the presentation cycle); SB/SH take 2 cycles with exactly 1 stall cycle.
- **Memory write:** lands at the posedge ending the cycle with `mem_we`=1. A load presented the next cycle sees the new data; no forwarding is needed.
- **Back-to-back:** SB, SB gives 4 cycles, stall pattern 1,0,1,0. SB then LW: the LW is accepted in the cycle after RMW_WR.
- **Combinational path:** `req_addr` → `mem_a` → `mem_rd` → `rsp_rdata`. This is the stage's critical path, and no register is added on it.
- **Handshake:** `stall` is a Moore-plus-request output: high only in IDLE with a valid, non-faulting SB/SH.

## Structure
- **Package `lsu_pkg`:**
  - funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - state enum `{IDLE, RMW_WR}`;
  - function `is_misaligned(funct3, addr_lo)`.
- **Sub-module `lsu_lane`:** purely combinational.
  - Load path: lane extract plus sign/zero extend.
  - Store path: lane merge of new data into the old word.
  - Instantiated once; `load_store_unit` keeps the FSM, registers and fault logic.

## Test plan
- Memory word 5 = 0x8899AABB:
  - LB at 0x15 → `rsp_rdata`=0xFFFFFFAA.
  - LBU at 0x15 → 0x000000AA.
  - LH at 0x16 → 0xFFFF8899.
  - `rsp_valid`=1 same cycle, `stall`=0.
- SB at 0x16 with `wdata`=0x12345677 on word 5 = 0x8899AABB:
  - cycle 1: `stall`=1, `mem_we`=0;
  - cycle 2: `mem_we`=1, `mem_wd`=0x8877AABB, `rsp_valid`=1;
  - LW at 0x14 on the next cycle → 0x8877AABB.
- SH at 0x13, LW at 0x16, LB with funct3=011, SW at 0x1000 (`MEM_WORDS`=1024) → each gives `fault`=1, `mem_we`=0 and memory unchanged.
- SW at 0x20 with 0xDEADBEEF → `mem_we`=1 same cycle, `mem_a`=8, no stall. LHU at 0x22 next cycle → 0x0000DEAD.
- `rst` asserted in the RMW_WR cycle of an SH → `mem_we`=0 and the word is unchanged. After `rst` deasserts: IDLE, and a new LW completes in 1 cycle.
- SB, SB, LW back-to-back at 0x14/0x15/0x14 → `stall` sequence 1,0,1,0,0; final `rsp_rdata` reflects both byte merges.
